pair_frame_accumulator: RTL and testbench

PAIR_FRAME_ACCUMULATOR -- requirements
Module: pair_frame_accumulator

---
 rtl/pair_frame_accumulator.sv | 131 +++++++++++++
 tb/tb_pair_frame_accumulator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_frame_accumulator.sv
// Accumulates decoded {any,both} pair codes over fixed-length frames and
// presents one saturated ones-count per frame through a held output register.
module pair_frame_accumulator #(
  parameter int FRAME_LEN = 4,
  parameter int SUM_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_err,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [7:0]     LAST    = 8'(FRAME_LEN - 1);
  localparam logic [SUM_W:0] SUM_MAX = {1'b0, {SUM_W{1'b1}}};

  logic             alive_q, alive_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] res_sum_q, res_sum_d;
  logic             res_err_q, res_err_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_valid_q, res_valid_d;

  logic             last_beat;
  logic             in_xfer;
  logic             out_xfer;
  logic [1:0]       dec;
  logic             code_err;
  logic [SUM_W:0]   sum_wide;
  logic             sat;
  logic [SUM_W-1:0] sum_sat;
  logic             frame_err;
  logic             frame_ovf;

  // alive_q holds in_ready low until the first edge after reset release.
  assign last_beat = (cnt_q == LAST);
  assign in_ready  = alive_q && !(last_beat && res_valid_q);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = res_valid_q && out_ready;

  assign out_sum   = res_sum_q;
  assign out_err   = res_err_q;
  assign out_ovf   = res_ovf_q;
  assign out_valid = res_valid_q;

  always_comb begin
    dec      = 2'd0;
    code_err = 1'b0;
    case (in_code)
      2'b10:   dec = 2'd1;
      2'b11:   dec = 2'd2;
      2'b01:   code_err = 1'b1;
      default: dec = 2'd0;
    endcase
  end

  always_comb begin
    sum_wide  = {1'b0, acc_q} + {{(SUM_W-1){1'b0}}, dec};
    sat       = (sum_wide > SUM_MAX);
    sum_sat   = sat ? SUM_MAX[SUM_W-1:0] : sum_wide[SUM_W-1:0];
    frame_err = err_q | code_err;
    frame_ovf = ovf_q | sat;
  end

  // A last-beat load can never coincide with an output transfer because
  // in_ready is low on the last beat whenever a result is still held.
  always_comb begin
    alive_d     = 1'b1;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    res_sum_d   = res_sum_q;
    res_err_d   = res_err_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    if (in_xfer && last_beat) begin
      cnt_d       = 8'd0;
      acc_d       = '0;
      err_d       = 1'b0;
      ovf_d       = 1'b0;
      res_sum_d   = sum_sat;
      res_err_d   = frame_err;
      res_ovf_d   = frame_ovf;
      res_valid_d = 1'b1;
    end else begin
      if (in_xfer) begin
        cnt_d = cnt_q + 8'd1;
        acc_d = sum_sat;
        err_d = frame_err;
        ovf_d = frame_ovf;
      end
      if (out_xfer) begin
        res_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q     <= 1'b0;
      cnt_q       <= 8'd0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      res_sum_q   <= '0;
      res_err_q   <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      alive_q     <= alive_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      res_sum_q   <= res_sum_d;
      res_err_q   <= res_err_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_pair_frame_accumulator.sv
// Scoreboard bench for pair_frame_accumulator across three parameter sets:
// u0 (FRAME_LEN=4, SUM_W=8), u1 (FRAME_LEN=4, SUM_W=2), u2 (FRAME_LEN=1).
module tb_pair_frame_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] inCode0 = '0, inCode1 = '0, inCode2 = '0;
  logic inValid0 = 0, inValid1 = 0, inValid2 = 0;
  logic outReady0 = 1, outReady1 = 1, outReady2 = 1;
  logic inReady0, inReady1, inReady2;
  logic outValid0, outValid1, outValid2;
  logic outErr0, outErr1, outErr2;
  logic outOvf0, outOvf1, outOvf2;
  logic [7:0] outSum0, outSum2;
  logic [1:0] outSum1;

  pair_frame_accumulator #(.FRAME_LEN(4), .SUM_W(8)) u0 (
    .clk(clk), .rst(rst), .in_code(inCode0), .in_valid(inValid0), .in_ready(inReady0),
    .out_sum(outSum0), .out_err(outErr0), .out_ovf(outOvf0), .out_valid(outValid0),
    .out_ready(outReady0));

  pair_frame_accumulator #(.FRAME_LEN(4), .SUM_W(2)) u1 (
    .clk(clk), .rst(rst), .in_code(inCode1), .in_valid(inValid1), .in_ready(inReady1),
    .out_sum(outSum1), .out_err(outErr1), .out_ovf(outOvf1), .out_valid(outValid1),
    .out_ready(outReady1));

  pair_frame_accumulator #(.FRAME_LEN(1), .SUM_W(8)) u2 (
    .clk(clk), .rst(rst), .in_code(inCode2), .in_valid(inValid2), .in_ready(inReady2),
    .out_sum(outSum2), .out_err(outErr2), .out_ovf(outOvf2), .out_valid(outValid2),
    .out_ready(outReady2));

  typedef struct packed {
    logic [15:0] sum;
    logic        err;
    logic        ovf;
  } expT;

  expT q0[$];
  expT q1[$];
  expT q2[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareResult(input string tag, input expT e, input int sum,
                               input logic err, input logic ovf);
    checkOutput({tag, " out_sum"}, sum, int'(e.sum));
    checkOutput({tag, " out_err"}, int'(err), int'(e.err));
    checkOutput({tag, " out_ovf"}, int'(ovf), int'(e.ovf));
  endtask

  function automatic logic readyOf(input int dut);
    case (dut)
      0:       return inReady0;
      1:       return inReady1;
      default: return inReady2;
    endcase
  endfunction

  // Presents one code and returns #1 after the edge on which it was accepted;
  // in_valid is left high so consecutive calls stream back-to-back.
  task automatic applyStimulus(input int dut, input logic [1:0] code);
    logic ok;
    ok = 1'b0;
    case (dut)
      0:       begin inValid0 = 1'b1; inCode0 = code; end
      1:       begin inValid1 = 1'b1; inCode1 = code; end
      default: begin inValid2 = 1'b1; inCode2 = code; end
    endcase
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = readyOf(dut);
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("accept timeout", 0, 1);
  endtask

  task automatic pushExp(input int dut, input int sum, input logic err, input logic ovf);
    expT e;
    e.sum = 16'(sum);
    e.err = err;
    e.ovf = ovf;
    case (dut)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst && outValid0 && outReady0) begin
      if (q0.size() == 0) checkOutput("u0 unexpected result", 1, 0);
      else compareResult("u0", q0.pop_front(), int'(outSum0), outErr0, outOvf0);
    end
  end

  always @(negedge clk) begin
    if (!rst && outValid1 && outReady1) begin
      if (q1.size() == 0) checkOutput("u1 unexpected result", 1, 0);
      else compareResult("u1", q1.pop_front(), int'(outSum1), outErr1, outOvf1);
    end
  end

  always @(negedge clk) begin
    if (!rst && outValid2 && outReady2) begin
      if (q2.size() == 0) checkOutput("u2 unexpected result", 1, 0);
      else compareResult("u2", q2.pop_front(), int'(outSum2), outErr2, outOvf2);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] readyPat;
    readyPat = 3'b101;

    // Reset values and first-cycle in_ready
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready u0", int'(inReady0), 0);
    checkOutput("reset out_valid u0", int'(outValid0), 0);
    checkOutput("reset out_sum u0", int'(outSum0), 0);
    checkOutput("reset in_ready u2", int'(inReady2), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_ready after release u0", int'(inReady0), 1);
    checkOutput("in_ready after release u1", int'(inReady1), 1);

    // 11,10,00,11 -> 5; out_valid for exactly one cycle
    pushExp(0, 5, 1'b0, 1'b0);
    applyStimulus(0, 2'b11);
    applyStimulus(0, 2'b10);
    applyStimulus(0, 2'b00);
    applyStimulus(0, 2'b11);
    inValid0 = 1'b0;
    checkOutput("latency out_valid", int'(outValid0), 1);
    @(posedge clk); #1;
    checkOutput("out_valid drop", int'(outValid0), 0);

    // Illegal code frame, then a clean frame
    pushExp(0, 4, 1'b1, 1'b0);
    applyStimulus(0, 2'b10);
    applyStimulus(0, 2'b01);
    applyStimulus(0, 2'b11);
    applyStimulus(0, 2'b10);
    pushExp(0, 1, 1'b0, 1'b0);
    applyStimulus(0, 2'b00);
    applyStimulus(0, 2'b00);
    applyStimulus(0, 2'b00);
    applyStimulus(0, 2'b10);
    inValid0 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Saturation with SUM_W=2
    pushExp(1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 2'b11);
    inValid1 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Back-pressure: held result, stall at last beat, release for one cycle
    outReady0 = 1'b0;
    pushExp(0, 4, 1'b0, 1'b0);
    pushExp(0, 4, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 2'b10);
    @(negedge clk);
    checkOutput("stall in_ready", int'(inReady0), 0);
    checkOutput("held out_valid", int'(outValid0), 1);
    @(posedge clk); #1;
    outReady0 = 1'b1;
    @(posedge clk); #1;
    outReady0 = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after release of result", int'(inReady0), 1);
    @(posedge clk); #1;
    inValid0 = 1'b0;
    checkOutput("re-presented out_valid", int'(outValid0), 1);
    outReady0 = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Reset mid-frame with a held result
    outReady0 = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b10);
    applyStimulus(0, 2'b11);
    applyStimulus(0, 2'b11);
    inValid0 = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid reset out_valid", int'(outValid0), 0);
    checkOutput("mid reset out_sum", int'(outSum0), 0);
    checkOutput("mid reset in_ready", int'(inReady0), 0);
    @(negedge clk);
    checkOutput("mid reset out_err", int'(outErr0), 0);
    checkOutput("mid reset out_ovf", int'(outOvf0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_ready after second release", int'(inReady0), 1);
    outReady0 = 1'b1;
    pushExp(0, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b10);
    inValid0 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // FRAME_LEN=1 with toggling out_ready
    inValid2 = 1'b1;
    inCode2 = 2'b11;
    for (int i = 0; i < 12; i++) begin
      outReady2 = readyPat[i % 3];
      @(negedge clk);
      checkOutput("u2 in_ready vs out_valid", int'(inReady2), int'(!outValid2));
      if (inReady2) pushExp(2, 2, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    inValid2 = 1'b0;
    outReady2 = 1'b1;
    repeat (3) @(posedge clk); #1;

    checkOutput("u0 leftover results", q0.size(), 0);
    checkOutput("u1 leftover results", q1.size(), 0);
    checkOutput("u2 leftover results", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
